pet_io_arb: RTL

Arbiter that shares the pet2001 I/O register port (PIA1, PIA2 and VIA at 0xE800-0xEFFF) between the 6502 and a host-side requester, such as the keystroke injector or debug bridge. The I/O block samples its strobe only on `ce` cycles and returns registered read data one cycle later. This block therefore assigns each `ce` slot to exactly one owner, steers address, data and write-enable to the I/O port, and returns host read data with a completion pulse. The CPU has priority. A starvation counter forces a host slot after repeated CPU I/O slots.

---
 rtl/pet_io_arb_if.sv | 26 ++
 rtl/pet_io_arb.sv | 103 ++++++++++
 2 files changed

// File: rtl/pet_io_arb_if.sv
`default_nettype none
// ============================================================================
// pet_io_arb_if : host-side request/acknowledge channel into pet_io_arb
// Rev 1.0 - initial release
// ============================================================================
interface pet_io_arb_if;
  logic        host_req;
  logic        host_we;
  logic [10:0] host_addr;
  logic [7:0]  host_din;
  logic        host_ack;
  logic [7:0]  host_dout;

  // Requester side (keystroke injector, debug bridge).
  modport master (
    output host_req, host_we, host_addr, host_din,
    input  host_ack, host_dout
  );

  // Arbiter side.
  modport slave (
    input  host_req, host_we, host_addr, host_din,
    output host_ack, host_dout
  );
endinterface
`default_nettype wire

// File: rtl/pet_io_arb.sv
`default_nettype none
// ============================================================================
// pet_io_arb : shares the PIA/VIA register port between the 6502 and a host
// Rev 1.0 - initial release
// ============================================================================
module pet_io_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic        ce,
  input  wire logic        cpu_sel,
  input  wire logic [10:0] cpu_addr,
  input  wire logic        cpu_we,
  input  wire logic [7:0]  cpu_din,
  output logic [7:0]       cpu_dout,
  output logic             cpu_rdy,
  pet_io_arb_if.slave      host,
  output logic [10:0]      io_addr,
  output logic             io_we,
  output logic [7:0]       io_din,
  input  wire logic [7:0]  io_dout
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_PEND = 2'd1;
  localparam logic [1:0] C_XFER = 2'd2;
  localparam logic [1:0] C_RESP = 2'd3;
  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic [3:0] r_starve_cnt;
  logic [7:0] r_host_dout;
  logic       r_host_we;
  logic       w_host_slot;
  logic       w_host_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      C_IDLE:  if (host.host_req) w_next = C_PEND;
      C_PEND:  if (w_host_slot)   w_next = C_XFER;
      C_XFER:  w_next = C_RESP;
      C_RESP:  w_next = C_IDLE;
      default: w_next = C_IDLE;
    endcase
  end

  // A stolen CPU slot is steered entirely to the host so the CPU access has
  // no side effect (no write, no flag-clearing read) until it is repeated.
  always_comb begin
    w_host_slot = ce && (r_state == C_PEND) &&
                  (!cpu_sel || (r_starve_cnt >= C_LIMIT));
    w_host_ack  = (r_state == C_RESP);
    cpu_rdy     = !(w_host_slot && cpu_sel);
    if (w_host_slot) begin
      io_addr = host.host_addr;
      io_we   = host.host_we;
      io_din  = host.host_din;
    end else begin
      io_addr = cpu_addr;
      io_we   = ce && cpu_we && cpu_sel;
      io_din  = cpu_din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= 4'd0;
      r_host_dout  <= 8'h00;
      r_host_we    <= 1'b0;
    end else begin
      if ((r_state == C_IDLE) || w_host_slot) begin
        r_starve_cnt <= 4'd0;
      end else if ((r_state == C_PEND) && ce && cpu_sel && (r_starve_cnt != 4'hF)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
      // Direction is latched at grant so a misbehaving requester cannot
      // corrupt the capture decision in XFER.
      if (w_host_slot) begin
        r_host_we <= host.host_we;
      end
      if ((r_state == C_XFER) && !r_host_we) begin
        r_host_dout <= io_dout;
      end
    end
  end

  assign host.host_ack  = w_host_ack;
  assign host.host_dout = r_host_dout;
  assign cpu_dout       = io_dout;

endmodule
`default_nettype wire
